// File: rtl/riscv_mem_pkg.sv
// Shared types for the fetch / load-store memory arbiter: FSM states, request
// owner and the latched memory request record.
package riscv_mem_pkg;

   localparam int unsigned MEM_XLEN   = 32;
   localparam int unsigned MEM_STRB_W = MEM_XLEN / 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_e;

   typedef enum logic {
      OWNER_INSN = 1'b0,
      OWNER_DATA = 1'b1
   } owner_e;

   typedef struct packed {
      logic [MEM_XLEN-1:0]   addr;
      logic                  write;
      logic [MEM_XLEN-1:0]   wdata;
      logic [MEM_STRB_W-1:0] strb;
   } mem_req_t;

endpackage

// File: rtl/riscv_mem_arbiter_if.sv
// Request/response channel: valid/ready request with address and store fields,
// followed by a single-cycle response pulse carrying read data.
interface riscv_mem_arbiter_if #(
   parameter int unsigned XLEN = 32
);
   logic              req_valid;
   logic              req_ready;
   logic [XLEN-1:0]   req_addr;
   logic              req_write;
   logic [XLEN-1:0]   req_wdata;
   logic [XLEN/8-1:0] req_strb;
   logic              resp_valid;
   logic [XLEN-1:0]   resp_rdata;

   // The side that issues requests and consumes responses.
   modport master (
      output req_valid, req_addr, req_write, req_wdata, req_strb,
      input  req_ready, resp_valid, resp_rdata
   );

   // The side that accepts requests and produces responses.
   modport slave (
      input  req_valid, req_addr, req_write, req_wdata, req_strb,
      output req_ready, resp_valid, resp_rdata
   );
endinterface

// File: rtl/riscv_mem_arb_select.sv
// Owner choice between fetch and load/store, with a saturating counter of
// consecutive data grants so a waiting fetch is eventually served.
module riscv_mem_arb_select
   import riscv_mem_pkg::*;
#(
   parameter int unsigned MAX_DATA_STREAK = 4
) (
   input  logic   clock,
   input  logic   reset_n,
   input  logic   idle_i,
   input  logic   insn_valid_i,
   input  logic   data_valid_i,
   output logic   grant_o,
   output owner_e owner_o
);

   localparam int unsigned CNT_W = $clog2(MAX_DATA_STREAK + 1);
   localparam logic [CNT_W-1:0] STREAK_MAX = CNT_W'(MAX_DATA_STREAK);

   logic [CNT_W-1:0] streak_q;
   logic [CNT_W-1:0] streak_d;
   logic             starve;

   always_comb begin
      starve   = insn_valid_i && (streak_q == STREAK_MAX);
      grant_o  = idle_i && (insn_valid_i || data_valid_i);
      owner_o  = (data_valid_i && !starve) ? OWNER_DATA : OWNER_INSN;
      streak_d = streak_q;
      // The streak only measures data grants taken while fetch was waiting.
      if (idle_i) begin
         if (!insn_valid_i || owner_o == OWNER_INSN) begin
            streak_d = '0;
         end else if (streak_q != STREAK_MAX) begin
            streak_d = streak_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         streak_q <= '0;
      end else begin
         streak_q <= streak_d;
      end
   end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store: one
// transaction in flight, issued with valid/ready and answered to its owner.
module riscv_mem_arbiter
   import riscv_mem_pkg::*;
#(
   parameter int unsigned XLEN            = MEM_XLEN,
   parameter int unsigned MAX_DATA_STREAK = 4
) (
   input  logic                clock,
   input  logic                reset_n,
   riscv_mem_arbiter_if.slave  insn_bus,
   riscv_mem_arbiter_if.slave  data_bus,
   riscv_mem_arbiter_if.master mem_bus,
   output logic                busy,
   output logic                err_spurious_resp
);

   state_e   state_q;
   owner_e   owner_q;
   mem_req_t req_q;
   logic     mem_req_valid_q;
   logic     busy_q;
   logic     err_q;

   logic     sel_idle;
   logic     accept;
   owner_e   sel_owner;
   mem_req_t next_req;
   logic     resp_fire;
   logic [XLEN-1:0] resp_data;

   // Fetch never writes, so its store fields are intentionally dropped.
   logic unused_insn_fields;
   assign unused_insn_fields = ^{insn_bus.req_write, insn_bus.req_wdata, insn_bus.req_strb};

   // Gating with reset_n keeps the request-ready outputs low while in reset.
   assign sel_idle = reset_n && (state_q == ST_IDLE);

   riscv_mem_arb_select #(
      .MAX_DATA_STREAK (MAX_DATA_STREAK)
   ) u_select (
      .clock        (clock),
      .reset_n      (reset_n),
      .idle_i       (sel_idle),
      .insn_valid_i (insn_bus.req_valid),
      .data_valid_i (data_bus.req_valid),
      .grant_o      (accept),
      .owner_o      (sel_owner)
   );

   always_comb begin
      next_req = '0;
      if (sel_owner == OWNER_DATA) begin
         next_req.addr  = data_bus.req_addr;
         next_req.write = data_bus.req_write;
         next_req.wdata = data_bus.req_wdata;
         next_req.strb  = data_bus.req_strb;
      end else begin
         next_req.addr  = insn_bus.req_addr;
      end
   end

   assign insn_bus.req_ready = accept && (sel_owner == OWNER_INSN);
   assign data_bus.req_ready = accept && (sel_owner == OWNER_DATA);

   // Responses pass straight through in the cycle memory delivers them.
   assign resp_fire           = (state_q == ST_WAIT) && mem_bus.resp_valid;
   assign resp_data           = mem_bus.resp_rdata;
   assign insn_bus.resp_valid = resp_fire && (owner_q == OWNER_INSN);
   assign data_bus.resp_valid = resp_fire && (owner_q == OWNER_DATA);
   assign insn_bus.resp_rdata = insn_bus.resp_valid ? resp_data : '0;
   assign data_bus.resp_rdata = data_bus.resp_valid ? resp_data : '0;

   assign mem_bus.req_valid = mem_req_valid_q;
   assign mem_bus.req_addr  = req_q.addr;
   assign mem_bus.req_write = req_q.write;
   assign mem_bus.req_wdata = req_q.wdata;
   assign mem_bus.req_strb  = req_q.strb;

   assign busy              = busy_q;
   assign err_spurious_resp = err_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q         <= ST_IDLE;
         owner_q         <= OWNER_INSN;
         req_q           <= '0;
         mem_req_valid_q <= 1'b0;
         busy_q          <= 1'b0;
         err_q           <= 1'b0;
      end else begin
         // A response with no issued transaction is a protocol error; it sticks.
         if (mem_bus.resp_valid && state_q != ST_WAIT) begin
            err_q <= 1'b1;
         end
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  owner_q         <= sel_owner;
                  req_q           <= next_req;
                  mem_req_valid_q <= 1'b1;
                  busy_q          <= 1'b1;
                  state_q         <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (mem_bus.req_ready) begin
                  mem_req_valid_q <= 1'b0;
                  state_q         <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (mem_bus.resp_valid) begin
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               mem_req_valid_q <= 1'b0;
               busy_q          <= 1'b0;
               state_q         <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
